// File: rtl/mult_pipe_signed.sv
// Pipelined RV32IM multiplier (MUL/MULH/MULHSU/MULHU) using sign-magnitude: |a|*|b|, then conditional negate.
// Latency: LATENCY cycles from accepted beat to out_valid; 1 beat/cycle while out_ready is high.
// Backpressure: global stall (out_valid & ~out_ready) freezes every stage; flush/rst clear all valid bits.
// Optional: define MULT_TAG_EN to carry a 5-bit destination register tag (in_tag -> out_tag) with each beat.
module mult_pipe_signed #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     result,
    output logic [2*WIDTH-1:0]   product
`ifdef MULT_TAG_EN
    ,
    input  logic [4:0]           in_tag,
    output logic [4:0]           out_tag
`endif
);

    localparam int PW   = 2 * WIDTH;
    localparam int LAST = LATENCY - 1;
    // Multiply stages after the operand-conditioning stage; each folds in one chunk of |b|.
    localparam int NS   = (LATENCY > 1) ? (LATENCY - 1) : 1;
    localparam int CW   = (WIDTH + NS - 1) / NS;
    localparam logic [PW-1:0] CMASK = (PW'(1) << CW) - PW'(1);

    // Per-stage state. Stage 0 holds the operand magnitudes; s_acc[i] is the running partial sum.
    logic [LATENCY-1:0] s_vld;
    logic [WIDTH-1:0]   s_am  [LATENCY];
    logic [WIDTH-1:0]   s_bm  [LATENCY];
    logic [1:0]         s_op  [LATENCY];
    logic               s_neg [LATENCY];
    logic [PW-1:0]      s_acc [LATENCY];
    logic [PW-1:0]      nxt_acc [LATENCY];
`ifdef MULT_TAG_EN
    logic [4:0]         s_tag [LATENCY];
`endif

    logic               stall;
    logic               a_signed;
    logic               b_signed;
    logic               sa;
    logic               sb;
    logic               in_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [PW-1:0]      full_p;
    logic [PW-1:0]      pp;
    logic [PW-1:0]      sum;

    assign out_valid = s_vld[LAST];
    assign stall     = out_valid & ~out_ready;
    assign in_ready  = ~stall;

    // Operand conditioning: strip signs so the core multiply is always unsigned.
    // Negating the most-negative value wraps back to 2^(WIDTH-1), which is the correct unsigned magnitude.
    always_comb begin
        a_signed = (op == 2'b01) || (op == 2'b10);
        b_signed = (op == 2'b01);
        sa       = a_signed & a[WIDTH-1];
        sb       = b_signed & b[WIDTH-1];
        in_neg   = sa ^ sb;
        a_mag    = sa ? -a : a;
        b_mag    = sb ? -b : b;
    end

    // Next partial sums: each multiply stage adds |a| times one CW-bit chunk of |b|;
    // the final stage also restores the product sign.
    always_comb begin
        for (int i = 0; i < LATENCY; i++) begin
            nxt_acc[i] = '0;
        end
        full_p = '0;
        pp     = '0;
        sum    = '0;
        if (LATENCY == 1) begin
            full_p     = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
            nxt_acc[0] = in_neg ? -full_p : full_p;
        end else begin
            for (int i = 1; i < LATENCY; i++) begin
                pp  = ({{WIDTH{1'b0}}, s_am[i-1]}
                       * (({{WIDTH{1'b0}}, s_bm[i-1]} >> ((i - 1) * CW)) & CMASK))
                      << ((i - 1) * CW);
                sum = s_acc[i-1] + pp;
                nxt_acc[i] = ((i == LAST) && s_neg[i-1]) ? -sum : sum;
            end
        end
    end

    // Valid bits: cleared by rst or flush (including the beat accepted this cycle), frozen on stall,
    // otherwise shifted one stage per cycle so bubbles are preserved.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            s_vld <= '0;
        end else if (!stall) begin
            for (int i = LATENCY - 1; i > 0; i--) begin
                s_vld[i] <= s_vld[i-1];
            end
            s_vld[0] <= in_valid;
        end
    end

    // Data registers: no reset needed, outputs are gated by out_valid. Held while stalled.
    always_ff @(posedge clk) begin
        if (!stall) begin
            s_am[0]  <= a_mag;
            s_bm[0]  <= b_mag;
            s_op[0]  <= op;
            s_neg[0] <= in_neg;
`ifdef MULT_TAG_EN
            s_tag[0] <= in_tag;
`endif
            for (int i = 1; i < LATENCY; i++) begin
                s_am[i]  <= s_am[i-1];
                s_bm[i]  <= s_bm[i-1];
                s_op[i]  <= s_op[i-1];
                s_neg[i] <= s_neg[i-1];
`ifdef MULT_TAG_EN
                s_tag[i] <= s_tag[i-1];
`endif
            end
            for (int i = 0; i < LATENCY; i++) begin
                s_acc[i] <= nxt_acc[i];
            end
        end
    end

    // Output selection: low half for MUL, high half otherwise; zero whenever nothing is valid.
    always_comb begin
        result  = '0;
        product = '0;
        if (out_valid) begin
            product = s_acc[LAST];
            result  = (s_op[LAST] == 2'b00) ? s_acc[LAST][WIDTH-1:0] : s_acc[LAST][PW-1:WIDTH];
        end
    end

`ifdef MULT_TAG_EN
    assign out_tag = out_valid ? s_tag[LAST] : 5'd0;
`endif

endmodule
